// File: rtl/axil_regbank_pkg.sv
// rtl/axil_regbank_pkg.sv - shared constants and byte-lane merge helper for the register bank
//
// Purpose:
//   Response codes, the word-address LSB and a strobe-merge function used by
//   axil_regbank_slave. The merge operates on a fixed maximum width so a single
//   function serves any C_DATA_WIDTH up to MAX_DATA_WIDTH; callers zero-extend
//   into it and take back the low C_DATA_WIDTH bits.
// Ports: none (package).

package axil_regbank_pkg;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_SLVERR    = 2'b10;
   localparam int         ADDR_LSB       = 2;
   localparam int         MAX_DATA_WIDTH = 64;

   // Byte-wise merge: strobed lanes take new_word, the rest keep old_word.
   function automatic logic [MAX_DATA_WIDTH-1:0] wstrb_merge(
      input logic [MAX_DATA_WIDTH-1:0]   old_word,
      input logic [MAX_DATA_WIDTH-1:0]   new_word,
      input logic [MAX_DATA_WIDTH/8-1:0] strb
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_word;
      for (int b = 0; b < MAX_DATA_WIDTH/8; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_regbank_slave.sv
// rtl/axil_regbank_slave.sv - AXI4-Lite slave register bank of NUM_REGS control/status words
//
// Purpose:
//   Single-beat AXI4-Lite slave. Write address and write data are captured
//   independently (either order or together) and committed one edge after both
//   are held; reads return the addressed register one edge after AR handshake.
//   Register contents are exposed flat on reg_out, with a one-cycle reg_wr_pulse
//   per register following each committed write.
//
// Configuration macro:
//   AXIL_REGBANK_SLVERR_EN - when defined, addresses with non-zero bits above the
//   register index are rejected with SLVERR (write dropped, read returns 0).
//   When undefined those bits are ignored and the bank aliases.
//
// Ports:
//   ACLK, ARESET                    clock, asynchronous active-high reset
//   AWADDR/AWPROT/AWVALID/AWREADY   write address channel (AWPROT ignored)
//   WDATA/WSTRB/WVALID/WREADY       write data channel
//   BRESP/BVALID/BREADY             write response channel
//   ARADDR/ARPROT/ARVALID/ARREADY   read address channel (ARPROT ignored)
//   RDATA/RRESP/RVALID/RREADY       read data channel
//   reg_out                         register k at [k*C_DATA_WIDTH +: C_DATA_WIDTH]
//   reg_wr_pulse                    bit k high for one cycle after register k commits

module axil_regbank_slave
   import axil_regbank_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 6,
   parameter int NUM_REGS     = 4
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic [C_ADDR_WIDTH-1:0]          AWADDR,
   input  logic [2:0]                       AWPROT,
   input  logic                             AWVALID,
   output logic                             AWREADY,
   input  logic [C_DATA_WIDTH-1:0]          WDATA,
   input  logic [C_DATA_WIDTH/8-1:0]        WSTRB,
   input  logic                             WVALID,
   output logic                             WREADY,
   output logic [1:0]                       BRESP,
   output logic                             BVALID,
   input  logic                             BREADY,
   input  logic [C_ADDR_WIDTH-1:0]          ARADDR,
   input  logic [2:0]                       ARPROT,
   input  logic                             ARVALID,
   output logic                             ARREADY,
   output logic [C_DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                       RRESP,
   output logic                             RVALID,
   input  logic                             RREADY,
   output logic [NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]              reg_wr_pulse
);

   localparam int IDX_W     = $clog2(NUM_REGS);
   localparam int STRB_W    = C_DATA_WIDTH / 8;
   localparam int RANGE_LSB = ADDR_LSB + IDX_W;

   logic [C_DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                    aw_hold;
   logic                    w_hold;
   logic [IDX_W-1:0]        aw_idx;
   logic                    aw_err;
   logic [C_DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]       w_strb;

   logic                    aw_hs;
   logic                    w_hs;
   logic                    ar_hs;
   logic                    commit;
   logic                    aw_range_err;
   logic                    ar_range_err;
   logic [IDX_W-1:0]        ar_idx;

   logic [MAX_DATA_WIDTH-1:0]   old_wide;
   logic [MAX_DATA_WIDTH-1:0]   new_wide;
   logic [MAX_DATA_WIDTH-1:0]   merge_wide;
   logic [MAX_DATA_WIDTH/8-1:0] strb_wide;
   logic                        unused_bits;

   // READY outputs are held low throughout reset so no beat is taken then.
   assign AWREADY = !ARESET && !aw_hold && !BVALID;
   assign WREADY  = !ARESET && !w_hold  && !BVALID;
   assign ARREADY = !ARESET && !RVALID;

   assign aw_hs  = AWVALID && AWREADY;
   assign w_hs   = WVALID  && WREADY;
   assign ar_hs  = ARVALID && ARREADY;
   assign commit = aw_hold && w_hold && !BVALID;
   assign ar_idx = ARADDR[ADDR_LSB +: IDX_W];

`ifdef AXIL_REGBANK_SLVERR_EN
   assign aw_range_err = |AWADDR[C_ADDR_WIDTH-1:RANGE_LSB];
   assign ar_range_err = |ARADDR[C_ADDR_WIDTH-1:RANGE_LSB];
   assign unused_bits  = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0],
                           merge_wide >> C_DATA_WIDTH};
`else
   assign aw_range_err = 1'b0;
   assign ar_range_err = 1'b0;
   assign unused_bits  = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0],
                           AWADDR[C_ADDR_WIDTH-1:RANGE_LSB], ARADDR[C_ADDR_WIDTH-1:RANGE_LSB],
                           merge_wide >> C_DATA_WIDTH};
`endif

   // Widen into the package helper's fixed width; only the low lanes come back.
   always_comb begin
      old_wide                     = '0;
      new_wide                     = '0;
      strb_wide                    = '0;
      old_wide[C_DATA_WIDTH-1:0]   = regs[aw_idx];
      new_wide[C_DATA_WIDTH-1:0]   = w_data;
      strb_wide[STRB_W-1:0]        = w_strb;
      merge_wide                   = wstrb_merge(old_wide, new_wide, strb_wide);
   end

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         reg_out[k*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[k];
      end
   end

   // Write capture and commit. AW and W are latched on their own handshakes;
   // the commit happens on the first edge where both are held and no response
   // is outstanding, which gives a two-edge latency from the later handshake.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_hold      <= 1'b0;
         w_hold       <= 1'b0;
         aw_idx       <= '0;
         aw_err       <= 1'b0;
         w_data       <= '0;
         w_strb       <= '0;
         BVALID       <= 1'b0;
         BRESP        <= RESP_OKAY;
         reg_wr_pulse <= '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         reg_wr_pulse <= '0;

         if (BVALID && BREADY) begin
            BVALID <= 1'b0;
         end

         if (aw_hs) begin
            aw_hold <= 1'b1;
            aw_idx  <= AWADDR[ADDR_LSB +: IDX_W];
            aw_err  <= aw_range_err;
         end

         if (w_hs) begin
            w_hold <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
         end

         if (commit) begin
            aw_hold <= 1'b0;
            w_hold  <= 1'b0;
            BVALID  <= 1'b1;
            if (aw_err) begin
               BRESP <= RESP_SLVERR;
            end else begin
               BRESP                <= RESP_OKAY;
               regs[aw_idx]         <= merge_wide[C_DATA_WIDTH-1:0];
               reg_wr_pulse[aw_idx] <= 1'b1;
            end
         end
      end
   end

   // Read capture. Sampling regs with a non-blocking read means a read taken on
   // the same edge as a commit to the same register returns the old contents.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         RVALID <= 1'b0;
         RDATA  <= '0;
         RRESP  <= RESP_OKAY;
      end else begin
         if (RVALID && RREADY) begin
            RVALID <= 1'b0;
         end

         if (ar_hs) begin
            RVALID <= 1'b1;
            if (ar_range_err) begin
               RDATA <= '0;
               RRESP <= RESP_SLVERR;
            end else begin
               RDATA <= regs[ar_idx];
               RRESP <= RESP_OKAY;
            end
         end
      end
   end

endmodule
